// File: rtl/maxpool_pkg.sv
// Shared types and defaults for the vertical max-pooling stage.
// Holds the lane-width default and the pair-position state encoding.
package maxpool_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int NUM_MODULES_DEF = 16;

    typedef enum logic [1:0] {
        EVEN = 2'd0,
        ODD  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/vmax_lane.sv
// Combinational signed maximum of two lanes; ties return the first operand,
// which is indistinguishable from the second.
module vmax_lane
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // select the larger two's-complement operand
    always_comb begin
        if ($signed(a) >= $signed(b)) begin
            y = a;
        end else begin
            y = b;
        end
    end

endmodule

// File: rtl/maxpool_vertical_stage.sv
// Vertical half of 2x2/stride-2 max pooling: pairs consecutive rows, keeps the
// even lanes of their lane-wise max and emits one pooled row per pair.
module maxpool_vertical_stage
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_MODULES = NUM_MODULES_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH*NUM_MODULES-1:0]     in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH*(NUM_MODULES/2)-1:0] out_data,
    output logic                                  out_last
);

    localparam int NUM_OUT = NUM_MODULES / 2;
    localparam int OUT_W   = DATA_WIDTH * NUM_OUT;

    state_t             state_r;
    state_t             state_s;
    // Only the even lanes of a buffered row can ever reach the output.
    logic [OUT_W-1:0]   row_buf_r;
    logic [OUT_W-1:0]   even_in_s;
    logic [OUT_W-1:0]   pair_max_s;
    logic [OUT_W-1:0]   out_data_s;
    logic               out_last_s;
    logic               capture_s;
    logic               accept_s;
    logic               retire_s;

    genvar j;
    generate
        for (j = 0; j < NUM_OUT; j++) begin : g_lane
            assign even_in_s[j*DATA_WIDTH +: DATA_WIDTH] = in_data[2*j*DATA_WIDTH +: DATA_WIDTH];

            vmax_lane #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_vmax (
                .a(row_buf_r[j*DATA_WIDTH +: DATA_WIDTH]),
                .b(even_in_s[j*DATA_WIDTH +: DATA_WIDTH]),
                .y(pair_max_s[j*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // input is refused only while a pooled row is held against backpressure
    always_comb begin
        if (state_r == OUT) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept_s = in_valid && in_ready;
    assign retire_s = out_valid && out_ready;

    // next state, row capture and output-register load decisions
    always_comb begin
        state_s    = state_r;
        capture_s  = 1'b0;
        out_data_s = out_data;
        out_last_s = out_last;
        case (state_r)
            EVEN: begin
                if (accept_s) begin
                    capture_s = 1'b1;
                    if (in_last) begin
                        out_data_s = even_in_s;
                        out_last_s = 1'b1;
                        state_s    = OUT;
                    end else begin
                        state_s    = ODD;
                    end
                end else begin
                    state_s = EVEN;
                end
            end
            ODD: begin
                if (accept_s) begin
                    out_data_s = pair_max_s;
                    out_last_s = in_last;
                    state_s    = OUT;
                end else begin
                    state_s = ODD;
                end
            end
            OUT: begin
                // A row accepted on the retire cycle starts a fresh pair.
                if (retire_s && accept_s) begin
                    capture_s = 1'b1;
                    if (in_last) begin
                        out_data_s = even_in_s;
                        out_last_s = 1'b1;
                        state_s    = OUT;
                    end else begin
                        out_last_s = 1'b0;
                        state_s    = ODD;
                    end
                end else if (retire_s) begin
                    out_last_s = 1'b0;
                    state_s    = EVEN;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                out_last_s = 1'b0;
                state_s    = EVEN;
            end
        endcase
    end

    // state, row buffer and registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= EVEN;
            row_buf_r <= {OUT_W{1'b0}};
            out_data  <= {OUT_W{1'b0}};
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_s;
            out_data  <= out_data_s;
            out_last  <= out_last_s;
            out_valid <= (state_s == OUT);
            if (capture_s) begin
                row_buf_r <= even_in_s;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_vertical_stage.sv
// Randomised scoreboard bench for maxpool_vertical_stage: a row-level reference
// model queues expected pooled rows, a negedge monitor retires and compares them.
module tb_maxpool_vertical_stage;
    import maxpool_pkg::*;

    localparam int DW = 16;
    localparam int NM = 16;
    localparam int NO = NM / 2;

    typedef logic [DW*NM-1:0] row_t;
    typedef logic [DW*NO-1:0] prow_t;
    typedef struct packed {
        logic  last;
        prow_t data;
    } exp_t;

    logic  clk;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    row_t  in_data;
    logic  in_last;
    logic  out_valid;
    logic  out_ready;
    prow_t out_data;
    logic  out_last;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;
    exp_t  exp_q[$];
    logic  have_pend = 1'b0;
    row_t  pend;
    logic  held = 1'b0;
    prow_t held_data;
    logic  held_last;
    logic  rand_ready = 1'b0;

    maxpool_vertical_stage #(
        .DATA_WIDTH(DW),
        .NUM_MODULES(NM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: even lanes of the element-wise signed max of two rows.
    function automatic prow_t pool_rows(input row_t a, input row_t b);
        prow_t r;
        for (int k = 0; k < NO; k++) begin
            int va;
            int vb;
            va = $signed(a[2*k*DW +: DW]);
            vb = $signed(b[2*k*DW +: DW]);
            r[k*DW +: DW] = (va > vb) ? va[DW-1:0] : vb[DW-1:0];
        end
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int k = 0; k < NM; k++) begin
            r[k*DW +: DW] = DW'($urandom);
        end
        return r;
    endfunction

    // Monitor + model: retire outputs first, then account for an accepted row.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            have_pend = 1'b0;
            held      = 1'b0;
            exp_q.delete();
        end else begin
            if (held) begin
                check("hold_data", 256'(out_data), 256'(held_data));
                check("hold_last", 256'(out_last), 256'(held_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 256'(out_data), 256'(e.data));
                    check("out_last", 256'(out_last), 256'(e.last));
                    n_out++;
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (in_valid && in_ready) begin
                if (have_pend) begin
                    exp_q.push_back({in_last, pool_rows(pend, in_data)});
                    have_pend = 1'b0;
                end else if (in_last) begin
                    exp_q.push_back({1'b1, pool_rows(in_data, in_data)});
                end else begin
                    pend      = in_data;
                    have_pend = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send_row(input row_t d, input logic last);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got no accept expected accept within 500 cycles");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        row_t a;
        row_t b;
        time  t0;
        int   base;
        int   waited;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        idle(3);
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_out_last", 256'(out_last), 256'(1'b0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1'b1));
        rst = 1'b0;
        idle(1);

        // 1: basic pair with one-cycle latency
        out_ready = 1'b1;
        for (int k = 0; k < NM; k++) begin
            a[k*DW +: DW] = DW'(k);
            b[k*DW +: DW] = DW'(15 - k);
        end
        send_row(a, 1'b0);
        send_row(b, 1'b0);
        @(negedge clk);
        check("pair_latency_valid", 256'(out_valid), 256'(1'b1));
        check("pair_lane0", 256'(out_data[15:0]), 256'(16'd15));
        check("pair_lane7", 256'(out_data[127:112]), 256'(16'd14));
        check("pair_last", 256'(out_last), 256'(1'b0));
        @(posedge clk);
        #1;
        idle(2);

        // 2: signed comparison
        a = rand_row();
        b = rand_row();
        a[15:0]  = 16'hFFFF;
        b[15:0]  = 16'h0002;
        a[47:32] = 16'hFFFB;
        b[47:32] = 16'hFFFD;
        send_row(a, 1'b0);
        send_row(b, 1'b0);
        @(negedge clk);
        check("signed_lane0", 256'(out_data[15:0]), 256'(16'h0002));
        check("signed_lane1", 256'(out_data[31:16]), 256'(16'hFFFD));
        @(posedge clk);
        #1;
        idle(2);

        // 3: three-row frame, last row flushed alone
        base = n_out;
        send_row(rand_row(), 1'b0);
        send_row(rand_row(), 1'b0);
        send_row(rand_row(), 1'b1);
        idle(4);
        check("flush_count", 256'(n_out - base), 256'(2));

        // 4: backpressure, then retire and accept on the same edge
        out_ready = 1'b0;
        send_row(rand_row(), 1'b0);
        send_row(rand_row(), 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 256'(in_ready), 256'(1'b0));
            check("bp_out_valid", 256'(out_valid), 256'(1'b1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_row(rand_row(), 1'b0);
        check("bp_state_odd", 256'(dut.state_r), 256'(ODD));
        send_row(rand_row(), 1'b1);
        idle(3);

        // 5: streaming eight rows back-to-back
        base = n_out;
        t0   = $time;
        for (int k = 0; k < 8; k++) begin
            send_row(rand_row(), 1'b0);
        end
        check("stream_no_stall", 256'($time - t0), 256'(80));
        idle(3);
        check("stream_count", 256'(n_out - base), 256'(4));

        // 6: reset mid-pair discards the buffered row
        a = rand_row();
        for (int k = 0; k < NM; k++) begin
            a[k*DW +: DW] = 16'h7000;
        end
        send_row(a, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 256'(out_valid), 256'(1'b0));
        @(posedge clk);
        #1;
        base = n_out;
        send_row(rand_row(), 1'b0);
        send_row(rand_row(), 1'b0);
        idle(3);
        check("rst_mid_count", 256'(n_out - base), 256'(1));

        // random frames with random gaps and backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            send_row(rand_row(), 1'($urandom_range(0, 3) == 0));
            idle(int'($urandom_range(0, 2)));
        end
        send_row(rand_row(), 1'b1);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        idle(2);
        check("drain_empty", 256'(exp_q.size()), 256'(0));
        check("drain_idle", 256'(out_valid), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
